// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end.
//   fetch_state_t    : fetch-stage FSM encoding (BOOT, RUN, HOLD)
//   DEFAULT_RESET_PC : default PC loaded on reset
//   DEFAULT_NOP_WORD : default instruction word used for IF/ID bubbles
//   word_align()     : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_stage_next_pc_select.sv
// ----------------------------------------------------------------------------
// next_pc_select
// Purely combinational redirect selector. The EX-stage branch is the oldest
// instruction in flight and therefore wins over the ID-stage jr, which in
// turn wins over the ID-stage j/jal.
//   branch, branch_target        : EX-resolved taken branch
//   jump_reg, jump_reg_target    : ID-stage jr
//   jump, jump_address           : ID-stage j/jal
//   request                      : any redirect is requested
//   target                       : selected raw (unaligned) target
//   misaligned                   : selected target has nonzero bits [1:0]
// ----------------------------------------------------------------------------
module next_pc_select (
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_target,
    input  logic        jump,
    input  logic [31:0] jump_address,
    output logic        request,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = jump_address;
        if (branch) begin
            target = branch_target;
        end else if (jump_reg) begin
            target = jump_reg_target;
        end
    end

    assign request    = branch | jump_reg | jump;
    assign misaligned = request & (|target[1:0]);

endmodule

// File: rtl/pc_fetch_stage.sv
// ----------------------------------------------------------------------------
// pc_fetch_stage
// Program counter and IF/ID pipeline register of the single-issue MIPS pipe.
//   Clk, Rst                 : rising-edge clock, asynchronous active-high reset
//   Stall                    : freezes PC and IF/ID
//   Branch/BranchTarget      : EX-stage taken branch
//   JumpReg/JumpRegTarget    : ID-stage jr
//   Jump/JumpAddress         : ID-stage j/jal
//   Instruction              : instruction-memory data for the current PC
//   PC                       : fetch address (register output only)
//   IF_ID_Instruction/_PCPlus4/_Valid : IF/ID pipeline register
//   RedirectPending          : a redirect was captured during a stall
//   Misaligned               : one-cycle pulse after a redirect whose raw
//                              target had bits [1:0] != 0 was applied
// ----------------------------------------------------------------------------
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        Jump,
    input  logic [31:0] JumpAddress,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        RedirectPending,
    output logic        Misaligned
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  if_id_instruction_reg;
    logic [31:0]  if_id_pc_plus4_reg;
    logic         if_id_valid_reg;
    logic         redirect_pending_reg;
    logic [31:0]  pending_target_reg;
    logic         misaligned_reg;

    logic         redirect_request;
    logic [31:0]  redirect_target;
    logic         redirect_misaligned;
    logic [31:0]  pc_plus4;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_reg + 32'd4;

    next_pc_select u_next_pc_select (
        .branch          (Branch),
        .branch_target   (BranchTarget),
        .jump_reg        (JumpReg),
        .jump_reg_target (JumpRegTarget),
        .jump            (Jump),
        .jump_address    (JumpAddress),
        .request         (redirect_request),
        .target          (redirect_target),
        .misaligned      (redirect_misaligned)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg             <= BOOT;
            pc_reg                <= RESET_PC;
            if_id_instruction_reg <= NOP_WORD;
            if_id_pc_plus4_reg    <= 32'd0;
            if_id_valid_reg       <= 1'b0;
            redirect_pending_reg  <= 1'b0;
            pending_target_reg    <= 32'd0;
            misaligned_reg        <= 1'b0;
        end else begin
            misaligned_reg <= 1'b0;
            case (state_reg)
                // First cycle after reset: let instruction memory settle on
                // RESET_PC before anything is latched.
                BOOT: begin
                    state_reg <= RUN;
                end

                RUN: begin
                    if (!Stall) begin
                        if (redirect_request) begin
                            // Redirect: squash the wrong-path fetch.
                            pc_reg                <= word_align(redirect_target);
                            if_id_instruction_reg <= NOP_WORD;
                            if_id_pc_plus4_reg    <= pc_plus4;
                            if_id_valid_reg       <= 1'b0;
                            misaligned_reg        <= redirect_misaligned;
                        end else begin
                            pc_reg                <= pc_plus4;
                            if_id_instruction_reg <= Instruction;
                            if_id_pc_plus4_reg    <= pc_plus4;
                            if_id_valid_reg       <= 1'b1;
                        end
                    end else if (redirect_request) begin
                        // Stalled redirect: remember the raw target so the
                        // misaligned flag can be raised when it is applied.
                        pending_target_reg   <= redirect_target;
                        redirect_pending_reg <= 1'b1;
                        state_reg            <= HOLD;
                    end
                end

                HOLD: begin
                    // Redirect inputs are ignored here: whatever is visible is
                    // the same request re-asserted by the stalled pipeline.
                    if (!Stall) begin
                        pc_reg                <= word_align(pending_target_reg);
                        if_id_instruction_reg <= NOP_WORD;
                        if_id_pc_plus4_reg    <= pc_plus4;
                        if_id_valid_reg       <= 1'b0;
                        redirect_pending_reg  <= 1'b0;
                        misaligned_reg        <= |pending_target_reg[1:0];
                        state_reg             <= RUN;
                    end
                end

                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign PC                = pc_reg;
    assign IF_ID_Instruction = if_id_instruction_reg;
    assign IF_ID_PCPlus4     = if_id_pc_plus4_reg;
    assign IF_ID_Valid       = if_id_valid_reg;
    assign RedirectPending   = redirect_pending_reg;
    assign Misaligned        = misaligned_reg;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_stage
// Self-checking bench for pc_fetch_stage: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        JumpReg = 1'b0;
    logic [31:0] JumpRegTarget = 32'd0;
    logic        Jump = 1'b0;
    logic [31:0] JumpAddress = 32'd0;
    logic [31:0] Instruction = 32'd0;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        RedirectPending;
    logic        Misaligned;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_ins, m_pp4, m_tgt;
    logic        m_valid, m_pend, m_mis;
    bit          m_booting, m_waiting;

    pc_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Stall             (Stall),
        .Branch            (Branch),
        .BranchTarget      (BranchTarget),
        .JumpReg           (JumpReg),
        .JumpRegTarget     (JumpRegTarget),
        .Jump              (Jump),
        .JumpAddress       (JumpAddress),
        .Instruction       (Instruction),
        .PC                (PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .RedirectPending   (RedirectPending),
        .Misaligned        (Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ins = NOP_WORD; m_pp4 = 32'd0; m_valid = 1'b0;
        m_pend = 1'b0; m_mis = 1'b0; m_tgt = 32'd0;
        m_booting = 1'b1; m_waiting = 1'b0;
    endtask

    // Apply the fetch rules for one rising edge using the current inputs.
    task automatic model_edge();
        bit          req;
        logic [31:0] sel;
        logic [31:0] seq;
        req = Branch || JumpReg || Jump;
        sel = Branch ? BranchTarget : (JumpReg ? JumpRegTarget : JumpAddress);
        seq = m_pc + 32'd4;
        m_mis = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_waiting) begin
            if (!Stall) begin
                m_mis   = (m_tgt % 4) != 0;
                m_pc    = m_tgt - (m_tgt % 4);
                m_ins   = NOP_WORD; m_pp4 = seq; m_valid = 1'b0;
                m_pend  = 1'b0; m_waiting = 1'b0;
            end
        end else if (Stall) begin
            if (req) begin
                m_tgt = sel; m_pend = 1'b1; m_waiting = 1'b1;
            end
        end else if (req) begin
            m_mis = (sel % 4) != 0;
            m_pc  = sel - (sel % 4);
            m_ins = NOP_WORD; m_pp4 = seq; m_valid = 1'b0;
        end else begin
            m_ins = Instruction; m_pp4 = seq; m_valid = 1'b1;
            m_pc  = seq;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    PC,                     m_pc);
        chk({tag, ".ins"},   IF_ID_Instruction,      m_ins);
        chk({tag, ".pp4"},   IF_ID_PCPlus4,          m_pp4);
        chk({tag, ".valid"}, {31'd0, IF_ID_Valid},     {31'd0, m_valid});
        chk({tag, ".pend"},  {31'd0, RedirectPending}, {31'd0, m_pend});
        chk({tag, ".mis"},   {31'd0, Misaligned},      {31'd0, m_mis});
    endtask

    // One clock: drive inputs, advance model at the edge, check #1 after.
    task automatic step(input string tag, input logic st,
                        input logic br, input logic [31:0] bt,
                        input logic jr, input logic [31:0] jrt,
                        input logic j,  input logic [31:0] ja,
                        input logic [31:0] ins);
        Stall = st; Branch = br; BranchTarget = bt; JumpReg = jr;
        JumpRegTarget = jrt; Jump = j; JumpAddress = ja; Instruction = ins;
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
        $display("step %-8s st=%0b br=%0b jr=%0b j=%0b pc=%h ifid=%h pp4=%h v=%0b pend=%0b mis=%0b",
                 tag, st, br, jr, j, PC, IF_ID_Instruction, IF_ID_PCPlus4,
                 IF_ID_Valid, RedirectPending, Misaligned);
    endtask

    task automatic idle(input string tag, input logic [31:0] ins);
        step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ins);
    endtask

    initial begin
        model_reset();
        // Reset held across edges
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        Rst = 1'b0;

        // Reset release: BOOT cycle, then first real fetch
        idle("boot", 32'h2008_0005);
        chk("boot.pc_held", PC, RESET_PC);
        idle("first", 32'h2008_0005);
        chk("first.pc", PC, 32'h4);
        chk("first.ins", IF_ID_Instruction, 32'h2008_0005);
        chk("first.pp4", IF_ID_PCPlus4, 32'h4);
        repeat (3) idle("seq", $urandom);
        chk("seq.pc10", PC, 32'h10);

        // Jump from 0x10 to 0x100, then sequential
        step("jump", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h100, 32'h1111_1111);
        chk("jump.pc", PC, 32'h100);
        chk("jump.valid", {31'd0, IF_ID_Valid}, 32'd0);
        idle("afterj", 32'h2222_2222);
        chk("afterj.pc", PC, 32'h104);

        // Priority: branch wins
        step("prio", 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h100, 32'h3);
        chk("prio.pc", PC, 32'h40);

        // Stalled jump held for three cycles, then release
        repeat (3) step("stallj", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200, 32'h4);
        chk("stallj.pc", PC, 32'h40);
        step("release", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300, 32'h5);
        chk("release.pc", PC, 32'h200);
        chk("release.pend", {31'd0, RedirectPending}, 32'd0);
        idle("postrel", 32'h6);

        // Misaligned jr target
        step("jrmis", 1'b0, 1'b0, 32'd0, 1'b1, 32'h123, 1'b0, 32'd0, 32'h7);
        chk("jrmis.pc", PC, 32'h120);
        chk("jrmis.flag", {31'd0, Misaligned}, 32'd1);
        idle("jrmis2", 32'h8);
        chk("jrmis2.flag", {31'd0, Misaligned}, 32'd0);

        // PC wrap
        step("towrap", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h9);
        idle("wrap", 32'hA);
        chk("wrap.pc", PC, 32'h0);
        chk("wrap.pp4", IF_ID_PCPlus4, 32'h0);

        // Asynchronous reset in HOLD
        step("tohold", 1'b1, 1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 32'd0, 32'hB);
        #3 Rst = 1'b1;
        #1;
        model_reset();
        check_all("asyncrst");
        #1 Rst = 1'b0;
        idle("boot2", 32'hC);
        idle("run2", 32'hD);

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t0, t1, t2;
            t0 = $urandom; t1 = $urandom; t2 = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                t0[1:0] = 2'b00; t1[1:0] = 2'b00; t2[1:0] = 2'b00;
            end
            step("rand", ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0), t0,
                 ($urandom_range(0, 9) == 0), t1,
                 ($urandom_range(0, 9) == 0), t2,
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
